// File: rtl/sipo_deser_if.sv
// Bus bundle for the serial-in/parallel-out deserialiser: serial input side,
// word output handshake, bit counter and sticky overflow flag.
interface sipo_deser_if #(
    parameter int DATA_WIDTH = 4,
    parameter int LANES      = 1
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                        din_valid;
    logic [LANES-1:0]            din;
    logic                        flush;
    logic [LANES*DATA_WIDTH-1:0] dout;
    logic                        dout_valid;
    logic                        dout_ready;
    logic [CNT_W-1:0]            bit_cnt;
    logic                        overflow;
    logic                        overflow_clr;

    // Link front-end / consumer side.
    modport master (
        output din_valid, din, flush, dout_ready, overflow_clr,
        input  dout, dout_valid, bit_cnt, overflow
    );

    // Deserialiser side.
    modport slave (
        input  din_valid, din, flush, dout_ready, overflow_clr,
        output dout, dout_valid, bit_cnt, overflow
    );
endinterface

// File: rtl/sipo_deser.sv
// Multi-lane serial-in/parallel-out deserialiser with a one-word output
// holding register (valid/ready), synchronous flush and sticky overflow.
module sipo_deser #(
    parameter int DATA_WIDTH = 4,
    parameter int LANES      = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input logic      clk,
    input logic      resetn,
    sipo_deser_if.slave bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    // dout_valid is the state bit itself.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    logic [DATA_WIDTH-1:0]       r_sh [LANES];
    logic [DATA_WIDTH-1:0]       w_sh_next [LANES];
    logic [LANES*DATA_WIDTH-1:0] w_word;
    logic [LANES*DATA_WIDTH-1:0] r_dout;
    logic [CNT_W-1:0]            r_bit_cnt;
    logic                        r_overflow;
    out_state_e                  r_state;
    out_state_e                  w_state_next;
    logic                        w_accept;
    logic                        w_complete;
    logic                        w_load;
    logic                        w_drop;

    // Flush beats din_valid, so a flushed bit is never counted or shifted.
    assign w_accept   = bus.din_valid && !bus.flush;
    assign w_complete = w_accept && (r_bit_cnt == LAST_CNT);

    // Per-lane next shift value; the completed word includes the current bit.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (DATA_WIDTH == 1) begin : g_w1
            assign w_sh_next[k] = bus.din[k];
        end else if (MSB_FIRST) begin : g_msb
            assign w_sh_next[k] = {r_sh[k][DATA_WIDTH-2:0], bus.din[k]};
        end else begin : g_lsb
            assign w_sh_next[k] = {bus.din[k], r_sh[k][DATA_WIDTH-1:1]};
        end
        assign w_word[k*DATA_WIDTH +: DATA_WIDTH] = w_sh_next[k];
    end

    // Shift registers: cleared by flush, advanced on each accepted bit.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the shift array is a small register bank, not RAM, so every
        // entry is reset; a real memory would be left unreset.
        if (!resetn) begin
            for (int k = 0; k < LANES; k++) r_sh[k] <= '0;
        end else if (bus.flush) begin
            for (int k = 0; k < LANES; k++) r_sh[k] <= '0;
        end else if (w_accept) begin
            // NOTE: non-blocking assignment keeps every lane reading the
            // pre-edge value regardless of statement order.
            for (int k = 0; k < LANES; k++) r_sh[k] <= w_sh_next[k];
        end
    end

    // Shared bit counter, wrapping on the completing bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bit_cnt <= '0;
        end else if (bus.flush || w_complete) begin
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output register next state: load, drop or drain.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        w_state_next = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_complete) begin
                    w_load       = 1'b1;
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_complete) begin
                    if (bus.dout_ready) w_load = 1'b1;
                    else                w_drop = 1'b1;
                end else if (bus.dout_ready) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Held word: only overwritten by a load, never cleared on consume.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dout <= '0;
        end else if (w_load) begin
            r_dout <= w_word;
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = (r_state == ST_FULL);
    assign bus.bit_cnt    = r_bit_cnt;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: three instances (W4/L2/MSB-first,
// W4/L1/LSB-first, W1/L1) share control stimulus; a bit-list reference
// model feeds per-instance scoreboards checked on each output handshake.
module tb_sipo_deser;
    logic clk;
    logic resetn;

    sipo_deser_if #(.DATA_WIDTH(4), .LANES(2)) if_a ();
    sipo_deser_if #(.DATA_WIDTH(4), .LANES(1)) if_b ();
    sipo_deser_if #(.DATA_WIDTH(1), .LANES(1)) if_c ();

    sipo_deser #(.DATA_WIDTH(4), .LANES(2), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .resetn(resetn), .bus(if_a.slave));
    sipo_deser #(.DATA_WIDTH(4), .LANES(1), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .resetn(resetn), .bus(if_b.slave));
    sipo_deser #(.DATA_WIDTH(1), .LANES(1), .MSB_FIRST(1'b1)) u_c (
        .clk(clk), .resetn(resetn), .bus(if_c.slave));

    // Shared control stimulus, per-instance serial data.
    logic       din_valid, flush, dout_ready, overflow_clr;
    logic [1:0] din_a;
    logic       din_b, din_c;

    assign if_a.din_valid = din_valid;  assign if_b.din_valid = din_valid;  assign if_c.din_valid = din_valid;
    assign if_a.flush = flush;          assign if_b.flush = flush;          assign if_c.flush = flush;
    assign if_a.dout_ready = dout_ready; assign if_b.dout_ready = dout_ready; assign if_c.dout_ready = dout_ready;
    assign if_a.overflow_clr = overflow_clr; assign if_b.overflow_clr = overflow_clr; assign if_c.overflow_clr = overflow_clr;
    assign if_a.din = din_a;
    assign if_b.din = din_b;
    assign if_c.din = din_c;

    // Uniform view of the three instances' outputs.
    logic [7:0] o_dout [3];
    logic       o_valid [3];
    logic [1:0] o_cnt [3];
    logic       o_ov [3];
    assign o_dout[0] = if_a.dout;          assign o_valid[0] = if_a.dout_valid;
    assign o_dout[1] = {4'b0, if_b.dout};  assign o_valid[1] = if_b.dout_valid;
    assign o_dout[2] = {7'b0, if_c.dout};  assign o_valid[2] = if_c.dout_valid;
    assign o_cnt[0] = if_a.bit_cnt;        assign o_ov[0] = if_a.overflow;
    assign o_cnt[1] = if_b.bit_cnt;        assign o_ov[1] = if_b.overflow;
    assign o_cnt[2] = {1'b0, if_c.bit_cnt}; assign o_ov[2] = if_c.overflow;

    // Reference model configuration and state.
    int         cfg_w [3]   = '{4, 4, 1};
    int         cfg_l [3]   = '{2, 1, 1};
    bit         cfg_msb [3] = '{1'b1, 1'b0, 1'b1};
    int         m_cnt [3];
    bit         m_full [3];
    bit         m_ov [3];
    bit         m_bits [3][2][4];
    logic [7:0] exp_q [3][$];

    int  checks = 0;
    int  errors = 0;
    bit  done   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: bits are collected as a list; a completed word is built by
    // placing bit i at position i or W-1-i, then offered to a one-slot output.
    task automatic model_step(input int c, input bit v, input bit f, input bit r,
                              input bit clr, input logic [1:0] d);
        bit         complete;
        bit         drop;
        bit         consumed;
        logic [7:0] word;
        int         pos;
        complete = 1'b0;
        drop     = 1'b0;
        consumed = m_full[c] && r;
        if (f) begin
            m_cnt[c] = 0;
        end else if (v) begin
            for (int k = 0; k < cfg_l[c]; k++) m_bits[c][k][m_cnt[c]] = d[k];
            m_cnt[c]++;
            if (m_cnt[c] == cfg_w[c]) begin
                complete = 1'b1;
                m_cnt[c] = 0;
            end
        end
        if (complete) begin
            word = '0;
            for (int k = 0; k < cfg_l[c]; k++) begin
                for (int i = 0; i < cfg_w[c]; i++) begin
                    pos = k * cfg_w[c] + (cfg_msb[c] ? cfg_w[c] - 1 - i : i);
                    word[pos] = m_bits[c][k][i];
                end
            end
            if (!m_full[c] || r) begin
                exp_q[c].push_back(word);
                m_full[c] = 1'b1;
            end else begin
                drop    = 1'b1;
                m_ov[c] = 1'b1;
            end
        end else if (consumed) begin
            m_full[c] = 1'b0;
        end
        if (clr && !drop) m_ov[c] = 1'b0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_cnt[c]  = 0;
            m_full[c] = 1'b0;
            m_ov[c]   = 1'b0;
            exp_q[c].delete();
        end
    endtask

    // Drive one clock's worth of inputs at the falling edge and advance the model.
    task automatic cycle(input bit v, input bit f, input bit r, input bit clr,
                         input logic [1:0] da, input logic db, input logic dc);
        @(negedge clk);
        din_valid = v; flush = f; dout_ready = r; overflow_clr = clr;
        din_a = da; din_b = db; din_c = dc;
        model_step(0, v, f, r, clr, da);
        model_step(1, v, f, r, clr, {1'b0, db});
        model_step(2, v, f, r, clr, {1'b0, dc});
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a word is compared exactly once, when it is handed over.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (resetn && !done) begin
                for (int c = 0; c < 3; c++) begin
                    if (o_valid[c] && dout_ready) begin
                        if (exp_q[c].size() == 0) begin
                            check($sformatf("unexpected_word[%0d]", c), 32'(o_dout[c]), 32'hFFFF_FFFF);
                        end else begin
                            check($sformatf("dout[%0d]", c), 32'(o_dout[c]), 32'(exp_q[c].pop_front()));
                        end
                    end
                end
            end
        end
    end

    // State monitor: valid, bit count and overflow after every edge.
    initial begin
        forever begin
            after_edge();
            if (resetn && !done) begin
                for (int c = 0; c < 3; c++) begin
                    check($sformatf("dout_valid[%0d]", c), 32'(o_valid[c]), 32'(m_full[c]));
                    check($sformatf("bit_cnt[%0d]", c), 32'(o_cnt[c]), 32'(m_cnt[c]));
                    check($sformatf("overflow[%0d]", c), 32'(o_ov[c]), 32'(m_ov[c]));
                end
            end
        end
    end

    logic [19:0] stream;
    logic [3:0]  rst_word;
    logic        b;

    initial begin
        resetn = 1'b0;
        din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0; overflow_clr = 1'b0;
        din_a = '0; din_b = 1'b0; din_c = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check("rst_dout", 32'(o_dout[c]), 0);
            check("rst_valid", 32'(o_valid[c]), 0);
            check("rst_cnt", 32'(o_cnt[c]), 0);
            check("rst_ov", 32'(o_ov[c]), 0);
        end
        resetn = 1'b1;

        // Bit order and latency: lane0 1101, lane1 0011, one idle gap.
        cycle(1, 0, 1, 0, 2'b01, 1, 1);
        cycle(1, 0, 1, 0, 2'b01, 1, 1);
        cycle(0, 0, 1, 0, 2'b00, 0, 0);
        cycle(1, 0, 1, 0, 2'b10, 0, 0);
        after_edge();
        check("latency_before", 32'(if_a.dout_valid), 0);
        cycle(1, 0, 1, 0, 2'b11, 1, 1);
        after_edge();
        check("latency_after", 32'(if_a.dout_valid), 1);
        check("a_word", 32'(if_a.dout), 32'h3D);
        check("b_lsb_first", 32'(if_b.dout), 32'hB);
        check("a_cnt_wrap", 32'(if_a.bit_cnt), 0);

        // Back-to-back words, no bubble.
        stream = 20'b1101_0110_0101_1100_0111;
        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < 4; i++) begin
                b = stream[19 - (w * 4 + i)];
                cycle(1, 0, 1, 0, {1'b0, b}, b, b);
            end
            after_edge();
            check("b2b_valid", 32'(if_a.dout_valid), 1);
            check("b2b_word", 32'(if_a.dout[3:0]), 32'(stream[19 - w * 4 -: 4]));
        end

        // Backpressure: second word dropped, overflow set, then drain and clear.
        cycle(0, 0, 1, 0, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, {1'b0, i != 2}, 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, {1'b0, i == 1 || i == 2}, 0, 0);
        after_edge();
        check("bp_keep", 32'(if_a.dout), 32'h0D);
        check("bp_overflow", 32'(if_a.overflow), 1);
        cycle(0, 0, 1, 0, 2'b00, 0, 0);
        after_edge();
        check("bp_drain", 32'(if_a.dout_valid), 0);
        cycle(0, 0, 0, 1, 2'b00, 0, 0);
        after_edge();
        check("bp_clr", 32'(if_a.overflow), 0);

        // Flush mid-word, then a clean word.
        cycle(1, 0, 1, 0, 2'b01, 1, 1);
        cycle(1, 0, 1, 0, 2'b00, 0, 0);
        cycle(0, 1, 1, 0, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, {1'b0, i[0]}, i[0], i[0]);
        after_edge();
        check("flush_word", 32'(if_a.dout[3:0]), 32'h5);

        // Flush together with the completing bit: no word.
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 2'b11, 1, 0);
        cycle(1, 1, 1, 0, 2'b11, 1, 0);
        after_edge();
        check("flush4_cnt", 32'(if_a.bit_cnt), 0);
        check("flush4_valid", 32'(if_a.dout_valid), 0);

        // Asynchronous reset mid-word (bit_cnt = 2).
        cycle(1, 0, 1, 0, 2'b01, 1, 0);
        cycle(1, 0, 1, 0, 2'b01, 1, 0);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("arst_dout", 32'(o_dout[c]), 0);
            check("arst_valid", 32'(o_valid[c]), 0);
            check("arst_cnt", 32'(o_cnt[c]), 0);
            check("arst_ov", 32'(o_ov[c]), 0);
        end
        model_reset();
        din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0; overflow_clr = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        rst_word = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            b = rst_word[3 - i];
            cycle(1, 0, 1, 0, {1'b0, b}, b, b);
            if (i < 2) begin
                after_edge();
                check("w1_word", 32'(if_c.dout), 32'(b));
            end
        end
        after_edge();
        check("post_rst_word", 32'(if_a.dout[3:0]), 32'h9);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                  2'($urandom), 1'($urandom), 1'($urandom));
        end

        // Drain and confirm every expected word was delivered.
        repeat (4) cycle(0, 0, 1, 0, 2'b00, 0, 0);
        after_edge();
        done = 1'b1;
        for (int c = 0; c < 3; c++) check($sformatf("queue_empty[%0d]", c), 32'(exp_q[c].size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Parametrised serial-in/parallel-out deserialiser, the successor to the single-lane DATA_WIDTH shifter. It adds:
- multiple lanes;
- selectable bit order;
- a din_valid qualifier;
- a one-word output holding register with a valid/ready handshake;
- a synchronous flush and a sticky overflow flag.

It sits between a bit-serial link front-end and word-wide consumer logic.

Parameters:
DATA_WIDTH, 4, bits per assembled word per lane (>=1)
LANES, 1, independent serial lanes sharing one bit counter and one handshake (>=1)
MSB_FIRST, 1, 1: first received bit lands in word MSB; 0: first bit lands in LSB

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
din_valid  in  1  din sampled this cycle
din  in  LANES  serial bit per lane (lane k = din[k])
flush  in  1  synchronous discard of partially assembled word
dout  out  LANES*DATA_WIDTH  held word; lane k = dout[k*DATA_WIDTH +: DATA_WIDTH]
dout_valid  out  1  dout holds an unconsumed word
dout_ready  in  1  consumer accepts dout when dout_valid&&dout_ready
bit_cnt  out  CNT_W  bits of current word received, CNT_W = max(1,$clog2(DATA_WIDTH))
overflow  out  1  sticky: a completed word was dropped
overflow_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (resetn low, asynchronous): shift registers, bit_cnt, dout, dout_valid and overflow go to 0 immediately and hold while low. Release is synchronous to the next clk edge.
- Shift, per lane on din_valid && !flush:
  - MSB_FIRST=1: sh <= {sh[W-2:0], din[k]}.
  - MSB_FIRST=0: sh <= {din[k], sh[W-1:1]}.
  - DATA_WIDTH=1: sh <= din[k].
  - Without din_valid, sh and bit_cnt hold.
- bit_cnt increments on each accepted bit and wraps to 0 on the DATA_WIDTH-th bit (the "complete" event).
- On the complete event, the assembled word (including the current bit) is offered to the output register in the same edge. dout_valid is seen high in the cycle after the final bit's sampling edge, so latency is 1 clk from the last bit.
- Output register states (dout_valid is the state bit):
  - EMPTY: complete -> load dout, go to FULL.
  - FULL, dout_ready=1, no complete -> go to EMPTY. dout keeps its last value, no clear.
  - FULL, dout_ready=1, complete in the same cycle -> load the new word, stay FULL. Back-to-back words have no bubble.
  - FULL, dout_ready=0, complete -> drop the new word, keep old dout, set overflow, stay FULL.
- Flush:
  - Clears bit_cnt and all shift registers next edge. Output register and overflow are unaffected.
  - flush with din_valid in the same cycle: flush wins and the bit is discarded, including a would-be completing bit (no word produced).
- overflow:
  - Set by a drop, cleared by overflow_clr.
  - Drop and overflow_clr in the same cycle: set wins.
- All lanes share bit_cnt, so all lanes complete simultaneously. Lanes never interact otherwise.
- No combinational path from din/din_valid to any output. dout_ready affects only next-state logic.

Test Plan:
- Bit order: W=4, L=1, MSB_FIRST=1, ready=1, bits 1,1,0,1 on consecutive cycles -> dout=4'b1101, dout_valid high exactly 1 cycle after 4th bit, bit_cnt back to 0.
- Same bits with MSB_FIRST=0 -> dout=4'b1011. Gaps of din_valid=0 between bits don't change the result.
- Back-to-back with ready=1: stream 1101_0110_0101_1100_0111 -> five words 1101,0110,0101,1100,0111. dout_valid stays high through each load, and each word is sampled once.
- Backpressure: ready=0, send 1101 then 0110 -> dout stays 1101 and overflow=1. Raise ready for 1 cycle -> dout_valid=0. Pulse overflow_clr -> overflow=0.
- Flush and reset: send 1,0 then flush, then 0101 -> dout=0101. Separately, assert resetn=0 mid-word (bit_cnt=2) between edges -> all outputs 0 before next edge. After release, 1001 -> dout=1001.
- Lanes and corners:
  - W=4, L=2, MSB_FIRST=1, lane0=1101, lane1=0011 -> dout=8'b0011_1101.
  - W=1, bits 1,0 -> two words 1 then 0.
  - flush with the 4th bit -> no word, bit_cnt=0.
